// File: rtl/data_mem_hs.sv
// Single-port data memory for the MEM stage with valid/ready request and response
// channels, programmable wait states, byte-enable writes and a sequenced post-reset clear.
module data_mem_hs #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 10,
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 0,
  parameter int INIT_CLEAR  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  input  logic [DATA_W/8-1:0]   req_be,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_W-1:0]     resp_rdata,
  output logic                  resp_err,
  output logic                  init_done
);

  localparam int BE_W = DATA_W / 8;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {CLEAR, IDLE, BUSY, RESP} state_t;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   clr_ptr;
  logic [3:0]          wait_cnt;
  logic                we_p0;
  logic [ADDR_W-1:0]   addr_p0;
  logic [DATA_W-1:0]   wdata_p0;
  logic [BE_W-1:0]     be_p0;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic                access;
  logic                in_range;

  function automatic logic [DATA_W-1:0] merge_bytes(input logic [DATA_W-1:0] old_w,
                                                    input logic [DATA_W-1:0] new_w,
                                                    input logic [BE_W-1:0]   be);
    logic [DATA_W-1:0] res;
    res = old_w;
    for (int b = 0; b < BE_W; b++)
      if (be[b]) res[8*b +: 8] = new_w[8*b +: 8];
    return res;
  endfunction

  assign access   = (state == BUSY) && (wait_cnt == 4'd0);
  assign in_range = {1'b0, addr_p0} < DEPTH_EXT;

  always_comb begin
    state_nxt = state;
    req_ready = (state == IDLE);
    case (state)
      CLEAR:   if (clr_ptr == LAST_ADDR) state_nxt = IDLE;
      IDLE:    if (req_valid) state_nxt = BUSY;
      BUSY:    if (wait_cnt == 4'd0) state_nxt = RESP;
      RESP:    if (resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= (INIT_CLEAR != 0) ? CLEAR : IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      clr_ptr    <= '0;
      wait_cnt   <= '0;
      init_done  <= (INIT_CLEAR == 0);
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
    end else begin
      case (state)
        CLEAR: begin
          clr_ptr <= clr_ptr + 1'b1;
          if (clr_ptr == LAST_ADDR) init_done <= 1'b1;
        end
        IDLE: if (req_valid) wait_cnt <= 4'(WAIT_CYCLES);
        BUSY: begin
          if (wait_cnt != 4'd0) begin
            wait_cnt <= wait_cnt - 1'b1;
          end else begin
            resp_valid <= 1'b1;
            resp_err   <= !in_range;
            resp_rdata <= (!we_p0 && in_range) ? mem[addr_p0] : '0;
          end
        end
        RESP: if (resp_ready) begin
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Request capture: data only, so no reset; later req_* changes are ignored
  always_ff @(posedge clk) begin
    if (state == IDLE && req_valid) begin
      we_p0    <= req_we;
      addr_p0  <= req_addr;
      wdata_p0 <= req_wdata;
      be_p0    <= req_be;
    end
  end

  // Array write port shared by the clear sequencer and committed writes; reset blocks both
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == CLEAR)
        mem[clr_ptr] <= '0;
      else if (access && we_p0 && in_range)
        mem[addr_p0] <= merge_bytes(mem[addr_p0], wdata_p0, be_p0);
    end
  end

endmodule

// File: tb/tb_data_mem_hs.sv
// Randomised self-checking bench for data_mem_hs against an array-based reference model.
module tb_data_mem_hs;
  localparam int DW = 16, AW = 10, DEP = 1000, WC = 2;

  logic clk = 1'b0;
  logic rst, req_valid, req_ready, req_we, resp_valid, resp_ready, resp_err, init_done;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata, resp_rdata;
  logic [1:0]    req_be;

  logic [DW-1:0] model [DEP];
  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  data_mem_hs #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEP), .WAIT_CYCLES(WC), .INIT_CLEAR(1)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err), .init_done(init_done));

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Reference model: error if out of range, byte-wise update for writes, word read otherwise
  task automatic mdl(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                     input logic [1:0] be, output logic [DW-1:0] erd, output logic eerr);
    eerr = (int'(a) >= DEP);
    erd  = '0;
    if (!eerr) begin
      if (we) begin
        for (int b = 0; b < 2; b++)
          if (be[b]) model[a][8*b +: 8] = wd[8*b +: 8];
      end else begin
        erd = model[a];
      end
    end
  endtask

  // One handshake; during the hold window a stray write to address 3 is offered and must be ignored
  task automatic access(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                        input logic [1:0] be, input int hold, output logic [DW-1:0] rd,
                        output logic err, output int lat, output logic stable);
    int w = 0;
    while (!req_ready && w < 50) begin tick(); w++; end
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = wd; req_be = be;
    tick();
    req_valid = 1'b0; req_we = 1'($urandom); req_addr = AW'($urandom);
    req_wdata = DW'($urandom); req_be = 2'($urandom);
    lat = 0;
    while (!resp_valid && lat < 20) begin tick(); lat++; end
    rd = resp_rdata; err = resp_err; stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      req_valid = 1'b1; req_we = 1'b1; req_addr = 10'd3; req_wdata = DW'($urandom); req_be = 2'b11;
      tick();
      if (!resp_valid || resp_rdata !== rd || resp_err !== err || req_ready) stable = 1'b0;
    end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0; req_valid = 1'b0;
    if (resp_valid || resp_err) stable = 1'b0;
  endtask

  task automatic wait_init(input string name);
    int cyc = 0;
    logic rdy_seen = 1'b0;
    while (!init_done && cyc < 1100) begin
      if (req_ready) rdy_seen = 1'b1;
      tick(); cyc++;
    end
    foreach (model[i]) model[i] = '0;
    n_chk++;
    if (cyc !== DEP || rdy_seen || !req_ready) begin
      n_fail++;
      $display("FAIL %s_clear: cycles=%0d ready_during_clear=%b ready_after=%b, expected cycles=%0d 0 1",
               name, cyc, rdy_seen, req_ready, DEP);
    end
  endtask

  task automatic check_acc(input string name, input logic we, input logic [AW-1:0] a,
                           input logic [DW-1:0] wd, input logic [1:0] be, input int hold);
    logic [DW-1:0] rd, erd;
    logic err, eerr, st;
    int lat;
    access(we, a, wd, be, hold, rd, err, lat, st);
    mdl(we, a, wd, be, erd, eerr);
    n_chk++;
    if (rd !== erd || err !== eerr || lat !== WC + 1 || st !== 1'b1) begin
      n_fail++;
      $display("FAIL %s: addr=%0d we=%b rdata=%h err=%b lat=%0d stable=%b, expected rdata=%h err=%b lat=%0d stable=1",
               name, a, we, rd, err, lat, st, erd, eerr, WC + 1);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; tick(); tick();
    n_chk++;
    if (resp_valid !== 1'b0 || resp_err !== 1'b0 || resp_rdata !== '0 || init_done !== 1'b0 || req_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: valid=%b err=%b rdata=%h init_done=%b ready=%b, expected all 0",
               resp_valid, resp_err, resp_rdata, init_done, req_ready);
    end
    rst = 1'b0;
    wait_init("reset");
    check_acc("read_cleared_0", 1'b0, 10'd0, '0, 2'b00, 0);
    check_acc("read_cleared_511", 1'b0, 10'd511, '0, 2'b00, 0);
    check_acc("read_cleared_999", 1'b0, 10'd999, '0, 2'b00, 0);
  endtask

  task automatic test_wait_states();
    check_acc("write_beef", 1'b1, 10'd5, 16'hBEEF, 2'b11, 0);
    check_acc("read_beef", 1'b0, 10'd5, '0, 2'b00, 0);
  endtask

  task automatic test_byte_enable();
    check_acc("write_be01", 1'b1, 10'd5, 16'h1234, 2'b01, 0);
    check_acc("read_be01", 1'b0, 10'd5, '0, 2'b00, 0);
    check_acc("write_be00", 1'b1, 10'd5, 16'h5678, 2'b00, 0);
    check_acc("read_be00", 1'b0, 10'd5, '0, 2'b00, 0);
    check_acc("write_be10", 1'b1, 10'd5, 16'hC3A5, 2'b10, 0);
    check_acc("read_be10", 1'b0, 10'd5, '0, 2'b00, 0);
  endtask

  task automatic test_range();
    check_acc("write_999", 1'b1, 10'd999, 16'h5A5A, 2'b11, 0);
    check_acc("write_oor_1000", 1'b1, 10'd1000, 16'hAAAA, 2'b11, 0);
    check_acc("read_oor_1000", 1'b0, 10'd1000, '0, 2'b00, 0);
    check_acc("read_oor_1023", 1'b0, 10'd1023, '0, 2'b00, 0);
    check_acc("read_999", 1'b0, 10'd999, '0, 2'b00, 0);
  endtask

  task automatic test_backpressure();
    check_acc("write_3", 1'b1, 10'd3, 16'h0F0F, 2'b11, 0);
    check_acc("read_held", 1'b0, 10'd3, '0, 2'b00, 5);
    check_acc("write_held", 1'b1, 10'd8, 16'h1357, 2'b11, 3);
    check_acc("read_3_after_stray", 1'b0, 10'd3, '0, 2'b00, 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++)
      check_acc("random", 1'($urandom), 10'($urandom_range(0, 1023)), DW'($urandom),
                2'($urandom), int'($urandom_range(0, 2)));
    for (int i = 0; i < 20; i++)
      check_acc("random_low", 1'($urandom), 10'($urandom_range(0, 15)), DW'($urandom),
                2'($urandom), 0);
  endtask

  task automatic test_reset_busy();
    check_acc("write_7", 1'b1, 10'd7, 16'h7777, 2'b11, 0);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 10'd7; req_wdata = 16'h1111; req_be = 2'b11;
    tick();
    req_valid = 1'b0;
    tick(); tick();
    rst = 1'b1; tick();
    rst = 1'b0;
    n_chk++;
    if (resp_valid !== 1'b0 || init_done !== 1'b0 || req_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_in_busy: valid=%b init_done=%b ready=%b, expected 0 0 0",
               resp_valid, init_done, req_ready);
    end
    wait_init("reset_busy");
    check_acc("read_7_after_reset", 1'b0, 10'd7, '0, 2'b00, 0);
    check_acc("read_5_after_reset", 1'b0, 10'd5, '0, 2'b00, 0);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    req_be = '0; resp_ready = 1'b0;
    test_reset();
    test_wait_states();
    test_byte_enable();
    test_range();
    test_backpressure();
    test_random();
    test_reset_busy();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
